// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and defaults for the uart transmit arbiter
//
// Contents:
//   arb_state_t            : arbiter FSM states
//   ACCEPT_TIMEOUT_DEFAULT : cycles allowed for tx_busy_i to rise after a write strobe
//   TIMEOUT_CNT_W          : width of the accept-timeout counter (covers timeouts up to 255)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STROBE    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } arb_state_t;

  localparam int ACCEPT_TIMEOUT_DEFAULT = 15;
  localparam int TIMEOUT_CNT_W          = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker
//
// Ports:
//   req        : request vector, one bit per requester
//   ptr        : index with highest priority; search ascends from here with wrap
//   winner_oh  : one-hot winner, all-zero when no request
//   winner_idx : binary index of the winner, 0 when no request
//   any        : at least one request is set
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  always_comb begin : pick
    logic found;
    found      = 1'b0;
    winner_oh  = '0;
    winner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!found && req[j]) begin
        found         = 1'b1;
        winner_oh[j]  = 1'b1;
        winner_idx    = IDX_W'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter in front of one uart_tx
//
// Ports:
//   clock_i     : clock, all state on rising edge
//   reset_i     : asynchronous active-low reset
//   req_valid_i : per-requester byte available
//   req_data_i  : byte k on bits [8k+7:8k]
//   req_last_i  : byte k ends its packet
//   req_ready_o : byte k accepted this cycle (combinational, at most one bit)
//   grant_o     : registered one-hot owner of the transmitter, zero when unowned
//   tx_write_o  : one-cycle write strobe to uart_tx
//   tx_data_o   : byte to uart_tx, stable from strobe until the byte completes
//   tx_busy_i   : uart_tx busy
//   timeout_o   : one-cycle pulse when uart_tx never acknowledged a strobe
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ACCEPT_TIMEOUT = ACCEPT_TIMEOUT_DEFAULT
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_write_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic                 timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t               state;
  logic [IDX_W-1:0]         ptr;
  logic [IDX_W-1:0]         win_idx;
  logic [IDX_W-1:0]         next_ptr;
  logic [IDX_W-1:0]         acc_idx;
  logic [7:0]               acc_byte;
  logic                     accept;
  logic                     last_q;
  logic [TIMEOUT_CNT_W-1:0] cnt;

  logic [NUM_REQ-1:0]       pick_oh;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_any;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid_i),
    .ptr        (ptr),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  // Accepts happen only in IDLE (open arbitration) or HOLD (locked owner
  // only). Ready is gated by reset so nothing is handed over while held.
  always_comb begin
    req_ready_o = '0;
    if (reset_i && !tx_busy_i) begin
      if (state == ST_IDLE && pick_any) begin
        req_ready_o = pick_oh;
      end else if (state == ST_HOLD && req_valid_i[win_idx]) begin
        req_ready_o = grant_o;
      end
    end
  end

  assign accept   = |req_ready_o;
  assign acc_idx  = (state == ST_HOLD) ? win_idx : pick_idx;
  assign acc_byte = req_data_i[8*acc_idx +: 8];
  assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      win_idx    <= '0;
      last_q     <= 1'b0;
      cnt        <= '0;
      grant_o    <= '0;
      tx_write_o <= 1'b0;
      tx_data_o  <= '0;
      timeout_o  <= 1'b0;
    end else begin
      tx_write_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            win_idx    <= pick_idx;
            grant_o    <= pick_oh;
            tx_data_o  <= acc_byte;
            last_q     <= req_last_i[acc_idx];
            tx_write_o <= 1'b1;
            state      <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          // uart_tx may not reflect the write yet, so busy is not looked at here.
          cnt   <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy_i) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt == TIMEOUT_CNT_W'(ACCEPT_TIMEOUT - 1)) begin
            // The strobe was lost; give up this owner, packet lock included.
            cnt       <= '0;
            timeout_o <= 1'b1;
            grant_o   <= '0;
            ptr       <= next_ptr;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy_i) begin
            if (last_q) begin
              grant_o <= '0;
              ptr     <= next_ptr;
              state   <= ST_IDLE;
            end else begin
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Packet lock: waits for the owner however long it takes.
          if (accept) begin
            tx_data_o  <= acc_byte;
            last_q     <= req_last_i[acc_idx];
            tx_write_o <= 1'b1;
            state      <= ST_STROBE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clock_i;
  logic        reset_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  grant_o;
  logic        tx_write_o;
  logic [7:0]  tx_data_o;
  logic        tx_busy_i;
  logic        timeout_o;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .ACCEPT_TIMEOUT (15)
  ) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .tx_write_o  (tx_write_o),
    .tx_data_o   (tx_data_o),
    .tx_busy_i   (tx_busy_i),
    .timeout_o   (timeout_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       busy;
    logic [3:0] exp_ready;
    logic [3:0] exp_grant;
    logic       exp_write;
    logic [7:0] exp_data;
    logic       exp_timeout;
  } vec_t;

  vec_t vecs [8];

  int n_cmp  = 0;
  int n_fail = 0;

  // requester / uart_tx model state
  int         rem [4];
  int         sent [4];
  logic       hold_off [4];
  int         busy_mode;
  int         pend;
  int         blen;
  logic       tx_free;
  int         cyc;
  int         last_acc_idx;
  logic [7:0] last_acc_byte;
  logic [3:0] to_grant;
  int         wr_idx_q [$];
  logic [7:0] wr_dat_q [$];
  int         wr_cyc_q [$];
  int         to_cyc_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int k, input int n);
    return 8'(8'h80 + k * 16 + n);
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    if (!$onehot(v)) return 99;
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 99;
  endfunction

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      req_valid_i[k]       = (rem[k] > 0) && !hold_off[k];
      req_last_i[k]        = (rem[k] == 1);
      req_data_i[k*8 +: 8] = byte_of(k, sent[k]);
    end
  endtask

  task automatic clear_logs();
    wr_idx_q.delete();
    wr_dat_q.delete();
    wr_cyc_q.delete();
    to_cyc_q.delete();
  endtask

  task automatic do_reset();
    reset_i   = 1'b0;
    tx_busy_i = 1'b0;
    busy_mode = 1;
    pend      = 0;
    blen      = 0;
    tx_free   = 1'b1;
    cyc       = 0;
    last_acc_idx  = 0;
    last_acc_byte = 8'h00;
    to_grant  = 4'h0;
    for (int k = 0; k < 4; k++) begin
      rem[k]      = 0;
      sent[k]     = 0;
      hold_off[k] = 1'b0;
    end
    clear_logs();
    drive();
    @(posedge clock_i);
    @(posedge clock_i);
    #1 reset_i = 1'b1;
  endtask

  // One clock: sample on the falling edge, then update requesters and the
  // uart_tx model just after the rising edge.
  task automatic tick();
    logic [3:0] rdy_s;
    logic [3:0] g_s;
    logic       w_s;
    logic       to_s;
    logic [7:0] d_s;
    int         k;
    @(negedge clock_i);
    rdy_s = req_ready_o;
    g_s   = grant_o;
    w_s   = tx_write_o;
    to_s  = timeout_o;
    d_s   = tx_data_o;
    check("ready_onehot_and_valid", {31'd0, $onehot0(rdy_s) && ((rdy_s & ~req_valid_i) == 4'h0)}, 32'd1);
    if (w_s) begin
      wr_idx_q.push_back(oh2i(g_s));
      wr_dat_q.push_back(d_s);
      wr_cyc_q.push_back(cyc);
      check("strobe_grant", {28'd0, g_s}, {28'd0, 4'(1 << last_acc_idx)});
      check("strobe_data", {24'd0, d_s}, {24'd0, last_acc_byte});
      check("strobe_after_tx_free", {31'd0, tx_free}, 32'd1);
      check("strobe_no_ready", {28'd0, rdy_s}, 32'd0);
      tx_free = 1'b0;
      if (busy_mode != 0) pend = 2;
    end
    if (to_s) begin
      to_cyc_q.push_back(cyc);
      to_grant = g_s;
      tx_free  = 1'b1;
    end
    if (rdy_s != 4'h0) begin
      k = oh2i(rdy_s);
      if (k < 4) begin
        last_acc_idx  = k;
        last_acc_byte = byte_of(k, sent[k]);
      end
    end
    @(posedge clock_i);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (rdy_s[i]) begin
        sent[i]++;
        rem[i]--;
      end
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        tx_busy_i = 1'b1;
        blen      = 4;
      end
    end else if (tx_busy_i) begin
      blen--;
      if (blen == 0) begin
        tx_busy_i = 1'b0;
        tx_free   = 1'b1;
      end
    end
    drive();
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int c;
    c = 0;
    while (wr_idx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    check({name, "_budget"}, {31'd0, wr_idx_q.size() >= n}, 32'd1);
  endtask

  task automatic check_entry(input string name, input int pos, input int idx, input logic [7:0] d);
    if (pos >= wr_idx_q.size()) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: write %0d missing, expected req %0d data 0x%0h", name, pos, idx, d);
    end else begin
      check({name, "_idx"}, wr_idx_q[pos], idx);
      check({name, "_data"}, {24'd0, wr_dat_q[pos]}, {24'd0, d});
    end
  endtask

  initial begin
    // table: single transfer from req 2, then pointer lands on req 3
    vecs[0] = '{4'b0100, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b1, 8'hA5, 1'b0};
    vecs[2] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b0, 8'hA5, 1'b0};
    vecs[3] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b0, 8'hA5, 1'b0};
    vecs[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b0, 8'hA5, 1'b0};
    vecs[5] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b0, 8'hA5, 1'b0};
    vecs[6] = '{4'b1111, 4'b1111, 1'b0, 4'b1000, 4'b0000, 1'b0, 8'hA5, 1'b0};
    vecs[7] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b1, 8'hB0, 1'b0};

    // reset values with requests pending
    reset_i     = 1'b0;
    tx_busy_i   = 1'b0;
    req_valid_i = 4'b1111;
    req_last_i  = 4'b1111;
    req_data_i  = 32'hB0A59080;
    #3;
    check("rst_grant", {28'd0, grant_o}, 32'd0);
    check("rst_write", {31'd0, tx_write_o}, 32'd0);
    check("rst_data", {24'd0, tx_data_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    check("rst_ready", {28'd0, req_ready_o}, 32'd0);

    do_reset();
    req_data_i = 32'hB0A59080;
    for (int i = 0; i < 8; i++) begin
      req_valid_i = vecs[i].valid;
      req_last_i  = vecs[i].last;
      tx_busy_i   = vecs[i].busy;
      @(negedge clock_i);
      check($sformatf("vec%0d_ready", i), {28'd0, req_ready_o}, {28'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d_grant", i), {28'd0, grant_o}, {28'd0, vecs[i].exp_grant});
      check($sformatf("vec%0d_write", i), {31'd0, tx_write_o}, {31'd0, vecs[i].exp_write});
      check($sformatf("vec%0d_data", i), {24'd0, tx_data_o}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_timeout", i), {31'd0, timeout_o}, {31'd0, vecs[i].exp_timeout});
      @(posedge clock_i);
      #1;
    end

    // contention: all four single-byte packets from reset
    do_reset();
    for (int k = 0; k < 4; k++) rem[k] = 1;
    drive();
    run_until("contend", 4, 300);
    for (int k = 0; k < 4; k++) check_entry($sformatf("contend%0d", k), k, k, byte_of(k, 0));

    // packet lock: req 1 three bytes, then req 3, then req 0
    do_reset();
    rem[1] = 3; rem[0] = 1; rem[3] = 1;
    hold_off[0] = 1'b1; hold_off[3] = 1'b1;
    drive();
    run_until("lock_first", 1, 50);
    hold_off[0] = 1'b0; hold_off[3] = 1'b0;
    drive();
    run_until("lock", 5, 400);
    check_entry("lock0", 0, 1, 8'h90);
    check_entry("lock1", 1, 1, 8'h91);
    check_entry("lock2", 2, 1, 8'h92);
    check_entry("lock3", 3, 3, 8'hB0);
    check_entry("lock4", 4, 0, 8'h80);

    // accept timeout: uart_tx never goes busy
    do_reset();
    busy_mode = 0;
    rem[0] = 1; rem[1] = 1;
    drive();
    run_until("timeout", 2, 100);
    check("timeout_count", to_cyc_q.size(), 1);
    if (to_cyc_q.size() > 0 && wr_cyc_q.size() > 0)
      check("timeout_delay", to_cyc_q[0] - wr_cyc_q[0], 16);
    check("timeout_grant", {28'd0, to_grant}, 32'd0);
    check_entry("timeout_next", 1, 1, 8'h90);

    // reset during WAIT_DONE, then arbitration restarts at index 0
    do_reset();
    rem[1] = 1; rem[2] = 1;
    drive();
    run_until("rstmid", 2, 100);
    tick();
    tick();
    check("rstmid_pre_grant", {28'd0, grant_o}, 32'h4);
    rem[0] = 1; rem[3] = 1;
    drive();
    #2 reset_i = 1'b0;
    #1;
    check("rstmid_grant", {28'd0, grant_o}, 32'd0);
    check("rstmid_write", {31'd0, tx_write_o}, 32'd0);
    check("rstmid_data", {24'd0, tx_data_o}, 32'd0);
    check("rstmid_timeout", {31'd0, timeout_o}, 32'd0);
    tx_busy_i = 1'b0;
    pend = 0;
    blen = 0;
    @(negedge clock_i);
    check("rstmid_ready_held", {28'd0, req_ready_o}, 32'd0);
    @(posedge clock_i);
    #1 reset_i = 1'b1;
    tx_free = 1'b1;
    clear_logs();
    run_until("rstmid_after", 1, 50);
    check_entry("rstmid_first", 0, 0, 8'h80);

    // HOLD stall: owner drops valid for a long time while others wait
    do_reset();
    rem[1] = 2; rem[0] = 1; rem[3] = 1;
    hold_off[0] = 1'b1; hold_off[3] = 1'b1;
    drive();
    run_until("stall_first", 1, 50);
    hold_off[0] = 1'b0; hold_off[3] = 1'b0; hold_off[1] = 1'b1;
    drive();
    repeat (30) tick();
    check("stall_no_grant", wr_idx_q.size(), 1);
    check("stall_grant_held", {28'd0, grant_o}, 32'h2);
    hold_off[1] = 1'b0;
    drive();
    run_until("stall", 3, 100);
    check_entry("stall0", 0, 1, 8'h90);
    check_entry("stall1", 1, 1, 8'h91);
    check_entry("stall2", 2, 3, 8'hB0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one uart_tx (range 2..8).
REQ-002 Parameter ACCEPT_TIMEOUT, default 15, clock cycles allowed for tx_busy_i to rise after a write strobe (range 2..255).
REQ-003 Port clock_i, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset_i, input, 1: asynchronous, active-low reset.
REQ-005 Port req_valid_i, input, NUM_REQ: per-requester byte available.
REQ-006 Port req_data_i, input, 8*NUM_REQ: byte k on bits [8k+7:8k].
REQ-007 Port req_last_i, input, NUM_REQ: byte k is the last byte of its packet.
REQ-008 Port req_ready_o, output, NUM_REQ: byte k accepted this cycle (valid&ready transfers).
REQ-009 Port grant_o, output, NUM_REQ: registered one-hot owner of the transmitter; all-zero when unowned.
REQ-010 Port tx_write_o, output, 1: write strobe to uart_tx write_i, active-high.
REQ-011 Port tx_data_o, output, 8: byte to uart_tx data_i.
REQ-012 Port tx_busy_i, input, 1: from uart_tx busy_o.
REQ-013 Port timeout_o, output, 1: one-cycle pulse on accept timeout.

Function
REQ-014 The FSM SHALL have states IDLE, STROBE, WAIT_BUSY, WAIT_DONE, HOLD.
REQ-015 IDLE: when any req_valid_i is set and tx_busy_i=0, the winner SHALL be chosen round-robin starting at index ptr, ascending with wrap.
REQ-016 In that IDLE cycle req_ready_o[winner] SHALL be 1 (combinational), the byte and its last flag captured, grant_o set to the winner next cycle, and the next state STROBE.
REQ-017 STROBE: tx_write_o=1 for exactly one cycle, then WAIT_BUSY; tx_busy_i is ignored in STROBE.
REQ-018 tx_data_o SHALL hold the captured byte unchanged from STROBE through WAIT_DONE.
REQ-019 WAIT_BUSY: on tx_busy_i=1 go to WAIT_DONE; a counter cleared on entry SHALL increment each cycle.
REQ-020 If the counter reaches ACCEPT_TIMEOUT without tx_busy_i, pulse timeout_o, clear grant_o, set ptr=winner+1 mod NUM_REQ, go to IDLE.
REQ-021 WAIT_DONE: on tx_busy_i=0, if the captured last flag is 1, clear grant_o, set ptr=winner+1 mod NUM_REQ, go to IDLE; otherwise go to HOLD.
REQ-022 HOLD: only the granted requester is served; when its valid is 1 and tx_busy_i=0, assert its req_ready_o, capture, go to STROBE; other requesters SHALL NOT be served while the packet lock is held.
REQ-023 HOLD SHALL wait indefinitely for the locked requester; there is no lock timeout.
REQ-024 req_ready_o SHALL be zero in STROBE, WAIT_BUSY and WAIT_DONE, and at most one bit SHALL ever be set.
REQ-025 Minimum per-byte arbiter overhead: accept cycle, STROBE cycle, then tx-dependent waits; back-to-back bytes SHALL need no idle cycle between WAIT_DONE exit and the next accept beyond the HOLD/IDLE accept cycle.
REQ-026 Changes on req_valid_i of non-granted requesters during a transfer SHALL have no effect.

Reset
REQ-027 While reset_i=0, the state SHALL be IDLE and ptr=0, with grant_o, tx_write_o, tx_data_o, timeout_o, req_ready_o and the counter all 0.
REQ-028 Reset asserted mid-transfer SHALL drop tx_write_o and grant_o immediately (asynchronously) and discard the captured byte.
REQ-029 After reset release, the first arbitration SHALL start at index 0.

Structure
REQ-030 The shared package uart_pkg SHALL hold the state enumeration and the default ACCEPT_TIMEOUT constant.
REQ-031 Round-robin selection SHALL be a combinational sub-module uart_rr_pick (inputs request vector and ptr; output one-hot winner and index).
REQ-032 The block SHALL connect directly to uart_tx with no glue logic.

Verification
REQ-033 Single: req 2 sends 0xA5 with last=1 -> one tx_write_o pulse with tx_data_o=0xA5, grant_o=0b0100 until busy falls, then 0, ptr=3.
REQ-034 Contention: all four valid with last=1 from reset -> served in order 0,1,2,3, each only after the previous busy falls.
REQ-035 Packet lock: req 1 sends 3 bytes (last on the 3rd) while req 0 and req 3 are valid -> req 1's bytes transmit consecutively, then req 3 is next, then req 0.
REQ-036 Timeout: tx_busy_i held 0 after the strobe -> timeout_o pulses 15 cycles after WAIT_BUSY entry, grant clears, the next requester is served.
REQ-037 Reset mid-operation: reset_i low during WAIT_DONE -> all outputs 0 at once; after release the first grant goes to index 0.
REQ-038 HOLD stall: a locked requester drops valid for 20 cycles with others valid -> no other grant occurs, and the transfer resumes when it revalidates.
